// File: rtl/l1i_cache_pkg.sv
// Shared types and constants for the L1 instruction cache.
// Holds the refill FSM encoding, the MMU word-width code and the counter helper.
package l1i_cache_pkg;

    typedef enum logic {
        L1I_IDLE   = 1'b0,
        L1I_REFILL = 1'b1
    } l1i_state_t;

    localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/l1i_cache_if.sv
// Fetch-side and MMU-side signal bundle of the L1 instruction cache.
// slave is the cache view; master is the view of the CPU/MMU environment.
interface l1i_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_flush;
    logic                  cpu_ready;
    logic [31:0]           cpu_instr;
    logic                  mmu_read_enable;
    logic [ADDR_WIDTH-1:0] mmu_address;
    logic [1:0]            mmu_mem_data_width;
    logic                  mmu_mem_signed_read;
    logic                  mmu_mem_ready;
    logic [31:0]           mmu_data_out;

    modport slave (
        input  cpu_req, cpu_addr, cpu_flush, mmu_mem_ready, mmu_data_out,
        output cpu_ready, cpu_instr, mmu_read_enable, mmu_address,
               mmu_mem_data_width, mmu_mem_signed_read
    );

    modport master (
        output cpu_req, cpu_addr, cpu_flush, mmu_mem_ready, mmu_data_out,
        input  cpu_ready, cpu_instr, mmu_read_enable, mmu_address,
               mmu_mem_data_width, mmu_mem_signed_read
    );
endinterface

// File: rtl/l1i_data_array.sv
// Instruction word storage: combinational read port, write port on clk.
// Read has zero latency; the write port is never stalled.
module l1i_data_array #(
    parameter int  NUM_LINES      = 16,
    parameter int  WORDS_PER_LINE = 4,
    localparam int IDX_W          = $clog2(NUM_LINES),
    localparam int WORD_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [NUM_LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_index, rd_word}];

endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped read-only L1I: hits answer in the same cycle, misses refill a line word by word.
// Miss latency is the sum of MMU word latencies plus one; the MMU request is held until mmu_mem_ready.
module l1i_cache
    import l1i_cache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    l1i_cache_if.slave  bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - 2 - WORD_W - IDX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

    l1i_state_t state, next_state;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem [NUM_LINES];
    logic [TAG_W-1:0]     refill_tag;
    logic [IDX_W-1:0]     refill_index;
    logic [WORD_W-1:0]    word_cnt;
    logic                 flush_pending;

    logic [TAG_W-1:0]      cur_tag;
    logic [IDX_W-1:0]      cur_index;
    logic [WORD_W-1:0]     cur_word;
    logic                  lookup_hit;
    logic                  hit;
    logic                  miss;
    logic                  fill_we;
    logic                  last_beat;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [31:0]           rd_data;
    logic                  unused_byte_offset;

    assign cur_word           = bus.cpu_addr[2 +: WORD_W];
    assign cur_index          = bus.cpu_addr[2 + WORD_W +: IDX_W];
    assign cur_tag            = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_byte_offset = ^bus.cpu_addr[1:0];

    assign lookup_hit = valid[cur_index] && (tag_mem[cur_index] == cur_tag);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= L1I_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        hit          = 1'b0;
        miss         = 1'b0;
        fill_we      = 1'b0;
        last_beat    = 1'b0;
        read_enable  = 1'b0;
        read_address = '0;
        case (state)
            L1I_IDLE: begin
                if (bus.cpu_req) begin
                    if (lookup_hit) begin
                        hit = 1'b1;
                    end else begin
                        miss       = 1'b1;
                        next_state = L1I_REFILL;
                    end
                end
            end
            L1I_REFILL: begin
                read_enable  = 1'b1;
                read_address = {refill_tag, refill_index, word_cnt, 2'b00};
                if (bus.mmu_mem_ready) begin
                    fill_we = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        last_beat  = 1'b1;
                        next_state = L1I_IDLE;
                    end
                end
            end
            default: next_state = L1I_IDLE;
        endcase
        // Outputs stay quiet for the whole time reset is held, not only after the edge.
        if (!reset_n) begin
            hit          = 1'b0;
            miss         = 1'b0;
            fill_we      = 1'b0;
            last_beat    = 1'b0;
            read_enable  = 1'b0;
            read_address = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid         <= '0;
            word_cnt      <= '0;
            flush_pending <= 1'b0;
            refill_tag    <= '0;
            refill_index  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            if (hit) begin
                hit_count <= sat_inc(hit_count);
            end
            if (miss) begin
                miss_count       <= sat_inc(miss_count);
                refill_tag       <= cur_tag;
                refill_index     <= cur_index;
                word_cnt         <= '0;
                flush_pending    <= 1'b0;
                valid[cur_index] <= 1'b0;
            end
            if (fill_we) begin
                word_cnt <= word_cnt + WORD_W'(1);
            end
            if (last_beat) begin
                if (!flush_pending) begin
                    valid[refill_index] <= 1'b1;
                end
                flush_pending <= 1'b0;
            end
            // A flush on the final beat already wipes the new line, so no pending flag is needed then.
            if (bus.cpu_flush) begin
                valid <= '0;
                if (state == L1I_REFILL && !last_beat) begin
                    flush_pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_mem[refill_index] <= refill_tag;
        end
    end

    l1i_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data_array (
        .clk      (clk),
        .wr_en    (fill_we),
        .wr_index (refill_index),
        .wr_word  (word_cnt),
        .wr_data  (bus.mmu_data_out),
        .rd_index (cur_index),
        .rd_word  (cur_word),
        .rd_data  (rd_data)
    );

    assign bus.cpu_ready           = hit;
    assign bus.cpu_instr           = rd_data;
    assign bus.mmu_read_enable     = read_enable;
    assign bus.mmu_address         = read_address;
    assign bus.mmu_mem_data_width  = MMU_WIDTH_WORD;
    assign bus.mmu_mem_signed_read = 1'b0;

endmodule
